mem_access_unit: RTL

MEM-stage consumer of the EX/MEM pipeline register. Takes the memory control and data fields latched by EX/MEM and runs word, halfword and byte loads and stores over a req/ack data-memory bus. Stalls the pipeline while a bus transaction is outstanding. Registers the results into the MEM/WB-facing outputs.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_lane_align.sv | 41 ++++
 rtl/mem_access_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and size codes for the MEM-stage data access path.
package mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    // Size code 2'b11 behaves as a word, so it shares the word alignment rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_HALF: is_misaligned = addr_lo[0];
            SZ_BYTE: is_misaligned = 1'b0;
            default: is_misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering for stores and lane extraction/extension for loads.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic        is_unsigned,
    output logic [3:0]  byte_en,
    output logic [31:0] bus_wdata,
    output logic [31:0] load_data
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        byte_en   = 4'b1111;
        bus_wdata = wdata;
        load_data = rdata;
        half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        byte_sel  = rdata[{addr_lo, 3'b000} +: 8];
        case (size)
            SZ_HALF: begin
                byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
                bus_wdata = {2{wdata[15:0]}};
                load_data = is_unsigned ? {16'h0000, half_sel}
                                        : {{16{half_sel[15]}}, half_sel};
            end
            SZ_BYTE: begin
                byte_en   = 4'b0001 << addr_lo;
                bus_wdata = {4{wdata[7:0]}};
                load_data = is_unsigned ? {24'h000000, byte_sel}
                                        : {{24{byte_sel[7]}}, byte_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: runs loads/stores over a req/ack bus, stalls while outstanding,
// and registers the MEM/WB-facing fields.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MemReadIn,
    input  logic        MemWriteIn,
    input  logic [1:0]  LoadIn,
    input  logic [1:0]  StoreIn,
    input  logic        LoadUnsignedIn,
    input  logic [31:0] AddrIn,
    input  logic [31:0] WriteDataIn,
    input  logic [4:0]  RegDstIn,
    input  logic        RegWriteIn,
    input  logic        MemToRegIn,
    output logic        BusReq,
    output logic        BusWe,
    output logic [31:0] BusAddr,
    output logic [31:0] BusWData,
    output logic [3:0]  BusByteEn,
    input  logic        BusAck,
    input  logic [31:0] BusRData,
    output logic        Stall,
    output logic [31:0] ReadDataOut,
    output logic [31:0] ALUResultOut,
    output logic [4:0]  RegDstOut,
    output logic        RegWriteOut,
    output logic        MemToRegOut,
    output logic        MisalignedExc,
    output logic        BusErr
);

    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic [31:0] l_addr, l_wdata;
    logic [1:0]  l_size;
    logic        l_store, l_uns, l_rw, l_m2r;
    logic [4:0]  l_rd;

    logic        access, mis, start, in_wait, expired;
    logic [1:0]  in_size;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, lane_ld;

    assign access  = MemReadIn | MemWriteIn;
    assign in_size = MemWriteIn ? StoreIn : LoadIn;
    assign mis     = access & is_misaligned(in_size, AddrIn[1:0]);
    assign in_wait = (state == WAIT);
    assign expired = (cnt == 8'd0);

    mem_lane_align u_align (
        .size        (l_size),
        .addr_lo     (l_addr[1:0]),
        .wdata       (l_wdata),
        .rdata       (BusRData),
        .is_unsigned (l_uns),
        .byte_en     (lane_be),
        .bus_wdata   (lane_wdata),
        .load_data   (lane_ld)
    );

    // Bus side is driven only from the latched copy so it stays put until acked.
    assign BusReq    = in_wait;
    assign BusWe     = in_wait & l_store;
    assign BusByteEn = in_wait ? lane_be : 4'b0000;
    assign BusAddr   = {l_addr[31:2], 2'b00};
    assign BusWData  = lane_wdata;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        Stall     = 1'b0;
        case (state)
            IDLE: begin
                start = access & ~mis;
                Stall = start;
                if (start) state_nxt = WAIT;
            end
            WAIT: begin
                Stall = ~BusAck & ~expired;
                if (BusAck || expired) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Stall must not hold up a pipeline that is itself being reset.
        Stall = Stall & Reset;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt           <= '0;
            l_addr        <= '0;
            l_wdata       <= '0;
            l_size        <= SZ_WORD;
            l_store       <= 1'b0;
            l_uns         <= 1'b0;
            l_rd          <= '0;
            l_rw          <= 1'b0;
            l_m2r         <= 1'b0;
            ReadDataOut   <= '0;
            ALUResultOut  <= '0;
            RegDstOut     <= '0;
            RegWriteOut   <= 1'b0;
            MemToRegOut   <= 1'b0;
            MisalignedExc <= 1'b0;
            BusErr        <= 1'b0;
        end else begin
            MisalignedExc <= 1'b0;
            BusErr        <= 1'b0;
            if (!in_wait) begin
                if (start) begin
                    l_addr      <= AddrIn;
                    l_wdata     <= WriteDataIn;
                    l_size      <= in_size;
                    l_store     <= MemWriteIn;
                    l_uns       <= LoadUnsignedIn;
                    l_rd        <= RegDstIn;
                    l_rw        <= RegWriteIn;
                    l_m2r       <= MemToRegIn;
                    cnt         <= 8'(TIMEOUT);
                    // Bubble downstream while the access is outstanding.
                    ReadDataOut <= '0;
                    RegWriteOut <= 1'b0;
                    MemToRegOut <= 1'b0;
                end else begin
                    ReadDataOut   <= '0;
                    ALUResultOut  <= AddrIn;
                    RegDstOut     <= RegDstIn;
                    RegWriteOut   <= RegWriteIn & ~mis;
                    MemToRegOut   <= MemToRegIn;
                    MisalignedExc <= mis;
                end
            end else if (BusAck) begin
                ReadDataOut  <= l_store ? 32'h0 : lane_ld;
                ALUResultOut <= l_addr;
                RegDstOut    <= l_rd;
                RegWriteOut  <= l_rw & ~l_store;
                MemToRegOut  <= l_m2r;
            end else if (expired) begin
                ReadDataOut  <= '0;
                ALUResultOut <= l_addr;
                RegDstOut    <= l_rd;
                RegWriteOut  <= 1'b0;
                MemToRegOut  <= l_m2r;
                BusErr       <= 1'b1;
            end else begin
                cnt <= cnt - 8'd1;
            end
        end
    end

endmodule
